mem_issue_queue: RTL and testbench

In-order load/store issue queue that feeds the memory pipeline of the Tomasulo core. It accepts memory ops from the issue stage, holds them until their base-address and store-data operands are resolved by snooping the common data bus (CDB), and dispatches them one per cycle, in program order, on the `mem_*_M` interface. The memory pipeline then computes the address from `srcA + srcB`, accesses data memory, and broadcasts on the CDB two cycles later.

---
 rtl/mem_issue_queue_if.sv | 48 ++++
 rtl/mem_issue_queue.sv | 169 ++++++++++++++++
 tb/tb_mem_issue_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_issue_queue_if.sv
// Issue-side, CDB and memory-pipeline signals of the mem issue queue.
// The queue takes the slave view; the issue stage / bench takes master.
interface mem_issue_queue_if #(
  parameter int DEPTH = 4
);
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic        alloc_read;
  logic        alloc_write;
  logic [2:0]  alloc_id;
  logic        alloc_a_wait;
  logic [2:0]  alloc_a_tag;
  logic [31:0] alloc_a_val;
  logic [31:0] alloc_imm;
  logic        alloc_d_wait;
  logic [2:0]  alloc_d_tag;
  logic [31:0] alloc_d_val;
  logic        cdb_valid;
  logic [2:0]  cdb_id;
  logic [31:0] cdb_value;
  logic        mem_MemRead_M;
  logic        mem_MemWrite_M;
  logic        mem_valid_M;
  logic [2:0]  mem_id_M;
  logic [31:0] mem_srcA_M;
  logic [31:0] mem_scrB_M;
  logic [31:0] mem_store_data_M;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output flush, alloc_valid, alloc_read, alloc_write, alloc_id,
    output alloc_a_wait, alloc_a_tag, alloc_a_val, alloc_imm,
    output alloc_d_wait, alloc_d_tag, alloc_d_val,
    output cdb_valid, cdb_id, cdb_value,
    input  alloc_ready, mem_MemRead_M, mem_MemWrite_M, mem_valid_M,
    input  mem_id_M, mem_srcA_M, mem_scrB_M, mem_store_data_M, count
  );

  modport slave (
    input  flush, alloc_valid, alloc_read, alloc_write, alloc_id,
    input  alloc_a_wait, alloc_a_tag, alloc_a_val, alloc_imm,
    input  alloc_d_wait, alloc_d_tag, alloc_d_val,
    input  cdb_valid, cdb_id, cdb_value,
    output alloc_ready, mem_MemRead_M, mem_MemWrite_M, mem_valid_M,
    output mem_id_M, mem_srcA_M, mem_scrB_M, mem_store_data_M, count
  );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: snoops the CDB for pending operands
// and dispatches one resolved op per cycle to the memory pipeline.
module mem_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  mem_issue_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [2:0]  id;
    logic        a_wait;
    logic [2:0]  a_tag;
    logic [31:0] a_val;
    logic [31:0] imm;
    logic        d_wait;
    logic [2:0]  d_tag;
    logic [31:0] d_val;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t head_ent;
  entry_t new_ent;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic alloc_ready;
  logic head_rdy;
  logic do_alloc;
  logic do_pop;

  logic        vld_q, vld_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [2:0]  id_q, id_d;
  logic [31:0] srca_q, srca_d;
  logic [31:0] srcb_q, srcb_d;
  logic [31:0] sdat_q, sdat_d;

  // Readiness uses stored state only, so a CDB hit dispatches next cycle.
  always_comb begin
    head_ent    = ent_q[head_q];
    alloc_ready = (count_q != CW'(DEPTH));
    head_rdy    = (count_q != '0) && !head_ent.a_wait &&
                  (!head_ent.write || !head_ent.d_wait);
    do_alloc    = bus.alloc_valid && alloc_ready && !bus.flush;
    do_pop      = head_rdy && !bus.flush;
  end

  always_comb begin
    new_ent.read   = bus.alloc_read;
    new_ent.write  = bus.alloc_write;
    new_ent.id     = bus.alloc_id;
    new_ent.a_wait = bus.alloc_a_wait;
    new_ent.a_tag  = bus.alloc_a_tag;
    new_ent.a_val  = bus.alloc_a_val;
    new_ent.imm    = bus.alloc_imm;
    new_ent.d_wait = bus.alloc_d_wait;
    new_ent.d_tag  = bus.alloc_d_tag;
    new_ent.d_val  = bus.alloc_d_val;
    if (bus.cdb_valid && bus.alloc_a_wait &&
        bus.alloc_a_tag == bus.cdb_id) begin
      new_ent.a_wait = 1'b0;
      new_ent.a_val  = bus.cdb_value;
    end
    if (bus.cdb_valid && bus.alloc_d_wait &&
        bus.alloc_d_tag == bus.cdb_id) begin
      new_ent.d_wait = 1'b0;
      new_ent.d_val  = bus.cdb_value;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (bus.cdb_valid && ent_q[i].a_wait &&
          ent_q[i].a_tag == bus.cdb_id) begin
        ent_d[i].a_wait = 1'b0;
        ent_d[i].a_val  = bus.cdb_value;
      end
      if (bus.cdb_valid && ent_q[i].d_wait &&
          ent_q[i].d_tag == bus.cdb_id) begin
        ent_d[i].d_wait = 1'b0;
        ent_d[i].d_val  = bus.cdb_value;
      end
    end
    if (do_alloc) ent_d[tail_q] = new_ent;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_alloc) tail_d = tail_q + 1'b1;
      if (do_pop) head_d = head_q + 1'b1;
      count_d = count_q + CW'(do_alloc) - CW'(do_pop);
    end
  end

  always_comb begin
    vld_d  = 1'b0;
    rd_d   = rd_q;
    wr_d   = wr_q;
    id_d   = id_q;
    srca_d = srca_q;
    srcb_d = srcb_q;
    sdat_d = sdat_q;
    if (do_pop) begin
      vld_d  = 1'b1;
      rd_d   = head_ent.read;
      wr_d   = head_ent.write;
      id_d   = head_ent.id;
      srca_d = head_ent.a_val;
      srcb_d = head_ent.imm;
      sdat_d = head_ent.write ? head_ent.d_val : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      id_q    <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      sdat_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      id_q    <= id_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      sdat_q  <= sdat_d;
    end
  end

  assign bus.alloc_ready      = alloc_ready;
  assign bus.count            = count_q;
  assign bus.mem_valid_M      = vld_q;
  assign bus.mem_MemRead_M    = rd_q;
  assign bus.mem_MemWrite_M   = wr_q;
  assign bus.mem_id_M         = id_q;
  assign bus.mem_srcA_M       = srca_q;
  assign bus.mem_scrB_M       = srcb_q;
  assign bus.mem_store_data_M = sdat_q;
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed per-cycle vector bench for mem_issue_queue (DEPTH=4),
// plus an asynchronous reset in the middle of traffic.
module tb_mem_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_issue_queue_if #(.DEPTH(4)) bus();

  mem_issue_queue #(.DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        av, rd, wr;
    logic [2:0]  id;
    logic        aw;
    logic [2:0]  at;
    logic [31:0] aval, imm;
    logic        dw;
    logic [2:0]  dt;
    logic [31:0] dval;
    logic        cv;
    logic [2:0]  cid;
    logic [31:0] cval;
    logic        fl;
    logic        ev, erd, ewr;
    logic [2:0]  eid;
    logic [31:0] ea, eb, ed;
    logic [2:0]  ecnt;
    logic        erdy;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    v.erdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t mo(input logic rd, wr, input logic [2:0] id,
                              input logic aw, input logic [2:0] at,
                              input logic [31:0] aval, imm,
                              input logic dw, input logic [2:0] dt,
                              input logic [31:0] dval);
    vec_t v;
    v = idle();
    v.av = 1'b1; v.rd = rd; v.wr = wr; v.id = id;
    v.aw = aw; v.at = at; v.aval = aval; v.imm = imm;
    v.dw = dw; v.dt = dt; v.dval = dval;
    return v;
  endfunction

  function automatic vec_t ld(input logic [2:0] id, input logic aw,
                              input logic [2:0] at,
                              input logic [31:0] aval, imm);
    return mo(1'b1, 1'b0, id, aw, at, aval, imm, 1'b0, 3'd0, 32'd0);
  endfunction

  function automatic vec_t st(input logic [2:0] id, input logic aw,
                              input logic [2:0] at,
                              input logic [31:0] aval, imm,
                              input logic dw, input logic [2:0] dt,
                              input logic [31:0] dval);
    return mo(1'b0, 1'b1, id, aw, at, aval, imm, dw, dt, dval);
  endfunction

  function automatic vec_t cdb(input vec_t vi, input logic [2:0] id,
                               input logic [31:0] val);
    vec_t v;
    v = vi; v.cv = 1'b1; v.cid = id; v.cval = val;
    return v;
  endfunction

  function automatic vec_t fl(input vec_t vi);
    vec_t v;
    v = vi; v.fl = 1'b1;
    return v;
  endfunction

  // Expect no dispatch at the following edge.
  function automatic vec_t ex(input vec_t vi, input logic [2:0] cnt,
                              input logic rdy);
    vec_t v;
    v = vi; v.ev = 1'b0; v.ecnt = cnt; v.erdy = rdy;
    return v;
  endfunction

  // Expect a dispatch with the given payload at the following edge.
  function automatic vec_t dp(input vec_t vi, input logic [2:0] cnt,
                              input logic rd, wr, input logic [2:0] id,
                              input logic [31:0] a, b, d);
    vec_t v;
    v = vi; v.ev = 1'b1; v.ecnt = cnt; v.erdy = (cnt != 3'd4);
    v.erd = rd; v.ewr = wr; v.eid = id; v.ea = a; v.eb = b; v.ed = d;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alloc_valid  = v.av;
    bus.alloc_read   = v.rd;
    bus.alloc_write  = v.wr;
    bus.alloc_id     = v.id;
    bus.alloc_a_wait = v.aw;
    bus.alloc_a_tag  = v.at;
    bus.alloc_a_val  = v.aval;
    bus.alloc_imm    = v.imm;
    bus.alloc_d_wait = v.dw;
    bus.alloc_d_tag  = v.dt;
    bus.alloc_d_val  = v.dval;
    bus.cdb_valid    = v.cv;
    bus.cdb_id       = v.cid;
    bus.cdb_value    = v.cval;
    bus.flush        = v.fl;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v);
    @(posedge clk);
    #1;
    chk("mem_valid_M", idx, 32'(bus.mem_valid_M), 32'(v.ev));
    chk("count", idx, 32'(bus.count), 32'(v.ecnt));
    chk("alloc_ready", idx, 32'(bus.alloc_ready), 32'(v.erdy));
    if (v.ev) begin
      chk("MemRead", idx, 32'(bus.mem_MemRead_M), 32'(v.erd));
      chk("MemWrite", idx, 32'(bus.mem_MemWrite_M), 32'(v.ewr));
      chk("id", idx, 32'(bus.mem_id_M), 32'(v.eid));
      chk("srcA", idx, bus.mem_srcA_M, v.ea);
      chk("scrB", idx, bus.mem_scrB_M, v.eb);
      chk("store_data", idx, bus.mem_store_data_M, v.ed);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, 0, 32'(bus.mem_valid_M), 32'd0);
    chk({nm, " rd"}, 0, 32'(bus.mem_MemRead_M), 32'd0);
    chk({nm, " wr"}, 0, 32'(bus.mem_MemWrite_M), 32'd0);
    chk({nm, " id"}, 0, 32'(bus.mem_id_M), 32'd0);
    chk({nm, " srcA"}, 0, bus.mem_srcA_M, 32'd0);
    chk({nm, " scrB"}, 0, bus.mem_scrB_M, 32'd0);
    chk({nm, " sdata"}, 0, bus.mem_store_data_M, 32'd0);
    chk({nm, " count"}, 0, 32'(bus.count), 32'd0);
  endtask

  initial begin
    drive(idle());

    // ready load: two-edge latency, one-cycle valid
    vq.push_back(ex(ld(3'd1, 1'b0, 3'd0, 32'h100, 32'd4), 3'd1, 1'b1));
    vq.push_back(dp(idle(), 3'd0, 1'b1, 1'b0, 3'd1, 32'h100, 32'd4, 32'd0));
    vq.push_back(ex(idle(), 3'd0, 1'b1));
    // store waits for data tag 5
    vq.push_back(ex(st(3'd2, 1'b0, 3'd0, 32'h20, 32'd0, 1'b1, 3'd5, 32'd0), 3'd1, 1'b1));
    vq.push_back(ex(idle(), 3'd1, 1'b1));
    vq.push_back(ex(idle(), 3'd1, 1'b1));
    vq.push_back(ex(cdb(idle(), 3'd5, 32'hDEAD), 3'd1, 1'b1));
    vq.push_back(dp(idle(), 3'd0, 1'b0, 1'b1, 3'd2, 32'h20, 32'd0, 32'hDEAD));
    vq.push_back(ex(idle(), 3'd0, 1'b1));
    // blocked head holds a ready younger op
    vq.push_back(ex(ld(3'd3, 1'b1, 3'd3, 32'd0, 32'd8), 3'd1, 1'b1));
    vq.push_back(ex(ld(3'd4, 1'b0, 3'd0, 32'h50, 32'd0), 3'd2, 1'b1));
    vq.push_back(ex(idle(), 3'd2, 1'b1));
    vq.push_back(ex(cdb(idle(), 3'd3, 32'h300), 3'd2, 1'b1));
    vq.push_back(dp(idle(), 3'd1, 1'b1, 1'b0, 3'd3, 32'h300, 32'd8, 32'd0));
    vq.push_back(dp(idle(), 3'd0, 1'b1, 1'b0, 3'd4, 32'h50, 32'd0, 32'd0));
    vq.push_back(ex(idle(), 3'd0, 1'b1));
    // allocate bypass from a same-cycle CDB hit
    vq.push_back(ex(cdb(ld(3'd7, 1'b1, 3'd6, 32'd0, 32'h10), 3'd6, 32'h40), 3'd1, 1'b1));
    vq.push_back(dp(idle(), 3'd0, 1'b1, 1'b0, 3'd7, 32'h40, 32'h10, 32'd0));
    vq.push_back(ex(idle(), 3'd0, 1'b1));
    // fill, overflow attempt, flush, stale entries stay dead
    vq.push_back(ex(ld(3'd0, 1'b1, 3'd7, 32'd0, 32'd0), 3'd1, 1'b1));
    vq.push_back(ex(ld(3'd1, 1'b1, 3'd7, 32'd0, 32'd0), 3'd2, 1'b1));
    vq.push_back(ex(ld(3'd2, 1'b1, 3'd7, 32'd0, 32'd0), 3'd3, 1'b1));
    vq.push_back(ex(ld(3'd3, 1'b1, 3'd7, 32'd0, 32'd0), 3'd4, 1'b0));
    vq.push_back(ex(ld(3'd5, 1'b0, 3'd0, 32'd5, 32'd0), 3'd4, 1'b0));
    vq.push_back(ex(fl(idle()), 3'd0, 1'b1));
    vq.push_back(ex(cdb(idle(), 3'd7, 32'd1), 3'd0, 1'b1));
    vq.push_back(ex(idle(), 3'd0, 1'b1));
    // allocate and dispatch in the same cycle, back to back
    vq.push_back(ex(ld(3'd1, 1'b0, 3'd0, 32'd1, 32'd0), 3'd1, 1'b1));
    vq.push_back(dp(ld(3'd2, 1'b0, 3'd0, 32'd2, 32'd0), 3'd1, 1'b1, 1'b0, 3'd1, 32'd1, 32'd0, 32'd0));
    vq.push_back(dp(idle(), 3'd0, 1'b1, 1'b0, 3'd2, 32'd2, 32'd0, 32'd0));
    vq.push_back(ex(idle(), 3'd0, 1'b1));
    // flush suppresses both dispatch and allocate
    vq.push_back(ex(ld(3'd3, 1'b0, 3'd0, 32'd3, 32'd0), 3'd1, 1'b1));
    vq.push_back(ex(fl(ld(3'd4, 1'b0, 3'd0, 32'd4, 32'd0)), 3'd0, 1'b1));
    vq.push_back(ex(idle(), 3'd0, 1'b1));
    // a load ignores pending d; a ready store carries its data
    vq.push_back(ex(mo(1'b1, 1'b0, 3'd4, 1'b0, 3'd0, 32'd4, 32'd0, 1'b1, 3'd2, 32'h99), 3'd1, 1'b1));
    vq.push_back(dp(idle(), 3'd0, 1'b1, 1'b0, 3'd4, 32'd4, 32'd0, 32'd0));
    vq.push_back(ex(st(3'd5, 1'b0, 3'd0, 32'd8, 32'd4, 1'b0, 3'd0, 32'h55), 3'd1, 1'b1));
    vq.push_back(dp(idle(), 3'd0, 1'b0, 1'b1, 3'd5, 32'd8, 32'd4, 32'h55));
    vq.push_back(ex(idle(), 3'd0, 1'b1));

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset alloc_ready", 0, 32'(bus.alloc_ready), 32'd1);
    rst = 1'b1;

    foreach (vq[i]) apply(vq[i], i + 1);

    // asynchronous reset with two entries queued and a dispatch showing
    apply(ex(ld(3'd1, 1'b1, 3'd4, 32'd0, 32'h10), 3'd1, 1'b1), 101);
    apply(ex(ld(3'd2, 1'b1, 3'd4, 32'd0, 32'h20), 3'd2, 1'b1), 102);
    apply(ex(cdb(ld(3'd3, 1'b1, 3'd5, 32'd0, 32'h30), 3'd4, 32'h444), 3'd3, 1'b1), 103);
    apply(dp(idle(), 3'd2, 1'b1, 1'b0, 3'd1, 32'h444, 32'h10, 32'd0), 104);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async reset");
    #2;
    rst = 1'b1;
    apply(ex(ld(3'd6, 1'b0, 3'd0, 32'h600, 32'd0), 3'd1, 1'b1), 105);
    apply(dp(idle(), 3'd0, 1'b1, 1'b0, 3'd6, 32'h600, 32'd0, 32'd0), 106);
    apply(ex(idle(), 3'd0, 1'b1), 107);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
